// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: feeds two 4*NIBBLES-bit operands through a 4-bit slice,
// LSB nibble first, with a start/busy/done handshake and a held result.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  part;
  logic [4:0]    nib_sum;
  logic [W+3:0]  part_ext;

  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {4'b0, ci};
  endfunction

  // Operands shift right each RUN cycle, so the current nibble is always at the
  // bottom; result nibbles enter from the top and land in place after NIBBLES steps.
  assign nib_sum  = nib_add(a_r[3:0], b_r[3:0], carry);
  assign part_ext = {nib_sum[3:0], part};

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      part  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            cnt   <= '0;
            carry <= 1'b0;
            part  <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          part  <= part_ext[W+3:4];
          carry <= nib_sum[4];
          if (cnt == LAST) begin
            sum   <= part_ext[W+3:4];
            cout  <= nib_sum[4];
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases plus randomized operands
// checked against plain a+b arithmetic.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] sum;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_sum = 16'h0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, checking sum stays at its held value; returns edges waited.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!done && n < 20) begin
      chk({tag, "_held"}, 32'(sum), 32'(prev_sum));
      tick();
      n++;
    end
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input string tag);
    logic [16:0] exp;
    int n;
    exp   = {1'b0, av} + {1'b0, bv};
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(exp[15:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[16]));
    prev_sum = exp[15:0];
    tick();
    chk({tag, "_done1"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h4321, "t1");
    do_op(16'hFFFF, 16'h0001, "t2");

    // Start held high across two operations; operands change during RUN.
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    a = 16'h0001; b = 16'h0002;
    wait_done("t3a", n);
    chk("t3a_lat", 32'(n), 32'd4);
    chk("t3a_sum", 32'(sum), 32'h0000FFFE);
    chk("t3a_cout", 32'(cout), 32'd1);
    prev_sum = 16'hFFFE;
    tick();
    chk("t3b_busy", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      chk("t3b_held", 32'(sum), 32'(prev_sum));
      tick();
      n++;
    end
    start = 1'b0;
    chk("t3b_lat", 32'(n), 32'd4);
    chk("t3b_sum", 32'(sum), 32'h00000003);
    chk("t3b_cout", 32'(cout), 32'd0);
    tick();
    chk("t3b_idle", 32'(busy | done), 32'd0);
    prev_sum = 16'h0003;

    // Asynchronous reset in the second RUN cycle.
    a = 16'h8000; b = 16'h8000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_sum", 32'(sum), 32'd0);
    chk("t4_cout", 32'(cout), 32'd0);
    #1 rst_n = 1'b1;
    prev_sum = 16'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_nodone", 32'(done | busy), 32'd0);
    end
    do_op(16'h0F0F, 16'h00F1, "t4r");

    // NIBBLES=1 instance.
    a1 = 4'hF; b1 = 4'h1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t6_busy", 32'(busy1), 32'd1);
    chk("t6_done0", 32'(done1), 32'd0);
    tick();
    chk("t6_busy0", 32'(busy1), 32'd0);
    chk("t6_done", 32'(done1), 32'd1);
    chk("t6_sum", 32'(sum1), 32'd0);
    chk("t6_cout", 32'(cout1), 32'd1);
    tick();
    chk("t6_done1", 32'(done1), 32'd0);

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("rnd_gap_held", 32'(sum), 32'(prev_sum));
        chk("rnd_gap_done", 32'(done), 32'd0);
      end
      do_op(16'($urandom), 16'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
